// File: rtl/booth4_pkg.sv
// Shared types for the iterative radix-4 Booth multiplier: FSM states,
// Booth digit select encoding and the digit decoder.
package booth4_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_CALC = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    typedef enum logic [2:0] {
        SEL_ZERO = 3'd0,
        SEL_PX   = 3'd1,
        SEL_P2X  = 3'd2,
        SEL_NX   = 3'd3,
        SEL_N2X  = 3'd4
    } booth_sel_t;

    // Radix-4 Booth recoding of one overlapping 3-bit multiplier window.
    function automatic booth_sel_t booth_decode(input logic [2:0] bits);
        booth_sel_t sel;
        case (bits)
            3'b001, 3'b010: sel = SEL_PX;
            3'b011:         sel = SEL_P2X;
            3'b100:         sel = SEL_N2X;
            3'b101, 3'b110: sel = SEL_NX;
            default:        sel = SEL_ZERO;
        endcase
        return sel;
    endfunction

endpackage

// File: rtl/booth4_mult_iter_if.sv
// Request/response bundle of booth4_mult_iter: operands and start in,
// busy/done/result out.
interface booth4_mult_iter_if #(
    parameter int WIDTH = 64
);
    logic                   start;
    logic                   is_signed;
    logic [WIDTH-1:0]       x;
    logic [WIDTH-1:0]       y;
    logic                   busy;
    logic                   done;
    logic [2*WIDTH-1:0]     result;

    modport master (
        output start, is_signed, x, y,
        input  busy, done, result
    );

    modport slave (
        input  start, is_signed, x, y,
        output busy, done, result
    );
endinterface

// File: rtl/booth4_pp_sel.sv
// Combinational Booth partial-product selector: one 3-bit multiplier window
// picks 0, +x, +2x, -x or -2x from the precomputed multiples.
module booth4_pp_sel
    import booth4_pkg::*;
#(
    parameter int WIDTH = 64
) (
    input  logic [2:0]       bits,
    input  logic [WIDTH+1:0] x_pos,
    input  logic [WIDTH+1:0] x_neg,
    input  logic [WIDTH+1:0] x2_pos,
    input  logic [WIDTH+1:0] x2_neg,
    output logic [WIDTH+1:0] pp
);
    booth_sel_t sel_s;

    // Decode the window and route the matching multiple.
    always_comb begin
        sel_s = booth_decode(bits);
        pp    = {(WIDTH+2){1'b0}};
        case (sel_s)
            SEL_PX:  pp = x_pos;
            SEL_P2X: pp = x2_pos;
            SEL_NX:  pp = x_neg;
            SEL_N2X: pp = x2_neg;
            default: pp = {(WIDTH+2){1'b0}};
        endcase
    end
endmodule

// File: rtl/booth4_mult_iter.sv
// Iterative radix-4 Booth multiplier, two bits of multiplier per cycle,
// signed or unsigned. Optional feature macro: BOOTH4_ZERO_BYPASS_EN.
module booth4_mult_iter
    import booth4_pkg::*;
#(
    parameter int WIDTH = 64
) (
    input  logic               clk,
    input  logic               rst_n,
    booth4_mult_iter_if.slave  bus
);
    localparam int EXT_W  = WIDTH + 2;
    // Two guard bits above the extended operand keep running sums from wrapping.
    localparam int ACC_W  = WIDTH + 4;
    localparam int MUL_W  = WIDTH + 3;
    localparam int N_ITER = WIDTH / 2 + 1;
    localparam int CNT_W  = $clog2(N_ITER + 1);

    state_t                  state_r, state_next_s;
    logic [EXT_W-1:0]        x_pos_r, x_neg_r, x2_pos_r, x2_neg_r;
    logic [ACC_W-1:0]        acc_r;
    logic [MUL_W-1:0]        mult_r;
    logic [CNT_W-1:0]        cnt_r;
    logic                    busy_r, done_r;
    logic [2*WIDTH-1:0]      result_r;

    logic [EXT_W-1:0]        x_ext_s, y_ext_s, x2_ext_s, pp_s;
    logic [ACC_W-1:0]        acc_sum_s;
    logic [ACC_W+MUL_W-1:0]  shifted_s;
    logic                    last_iter_s, zero_op_s;

    assign x_ext_s  = bus.is_signed ? {{2{bus.x[WIDTH-1]}}, bus.x} : {2'b00, bus.x};
    assign y_ext_s  = bus.is_signed ? {{2{bus.y[WIDTH-1]}}, bus.y} : {2'b00, bus.y};
    assign x2_ext_s = {x_ext_s[EXT_W-2:0], 1'b0};

`ifdef BOOTH4_ZERO_BYPASS_EN
    assign zero_op_s = (bus.x == {WIDTH{1'b0}}) || (bus.y == {WIDTH{1'b0}});
`else
    assign zero_op_s = 1'b0;
`endif

    assign last_iter_s = (cnt_r == CNT_W'(N_ITER - 1));

    booth4_pp_sel #(.WIDTH(WIDTH)) u_pp_sel (
        .bits   (mult_r[2:0]),
        .x_pos  (x_pos_r),
        .x_neg  (x_neg_r),
        .x2_pos (x2_pos_r),
        .x2_neg (x2_neg_r),
        .pp     (pp_s)
    );

    assign acc_sum_s = acc_r + {{2{pp_s[EXT_W-1]}}, pp_s};
    assign shifted_s = $signed({acc_sum_s, mult_r}) >>> 2;

    // FSM state register.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_next_s;
        end
    end

    // FSM next-state logic.
    always_comb begin
        state_next_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (bus.start) begin
                    if (zero_op_s) begin
                        state_next_s = ST_DONE;
                    end else begin
                        state_next_s = ST_CALC;
                    end
                end else begin
                    state_next_s = ST_IDLE;
                end
            end
            ST_CALC: begin
                if (last_iter_s) begin
                    state_next_s = ST_DONE;
                end else begin
                    state_next_s = ST_CALC;
                end
            end
            ST_DONE: state_next_s = ST_IDLE;
            default: state_next_s = ST_IDLE;
        endcase
    end

    // Operand capture, Booth iteration and registered outputs.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            x_pos_r  <= {EXT_W{1'b0}};
            x_neg_r  <= {EXT_W{1'b0}};
            x2_pos_r <= {EXT_W{1'b0}};
            x2_neg_r <= {EXT_W{1'b0}};
            acc_r    <= {ACC_W{1'b0}};
            mult_r   <= {MUL_W{1'b0}};
            cnt_r    <= {CNT_W{1'b0}};
            busy_r   <= 1'b0;
            done_r   <= 1'b0;
            result_r <= {(2*WIDTH){1'b0}};
        end else begin
            busy_r <= (state_next_s != ST_IDLE);
            done_r <= (state_next_s == ST_DONE);
            if (state_r == ST_IDLE && bus.start) begin
                x_pos_r  <= x_ext_s;
                x_neg_r  <= -x_ext_s;
                x2_pos_r <= x2_ext_s;
                x2_neg_r <= -x2_ext_s;
                acc_r    <= {ACC_W{1'b0}};
                mult_r   <= {y_ext_s, 1'b0};
                cnt_r    <= {CNT_W{1'b0}};
                if (zero_op_s) begin
                    result_r <= {(2*WIDTH){1'b0}};
                end
            end else if (state_r == ST_CALC) begin
                acc_r  <= shifted_s[ACC_W+MUL_W-1:MUL_W];
                mult_r <= shifted_s[MUL_W-1:0];
                cnt_r  <= cnt_r + CNT_W'(1'b1);
                // Bit 0 of the shifted pair is the spent Booth guard bit.
                if (last_iter_s) begin
                    result_r <= shifted_s[2*WIDTH:1];
                end
            end
        end
    end

    assign bus.busy   = busy_r;
    assign bus.done   = done_r;
    assign bus.result = result_r;
endmodule

// File: tb/tb_booth4_mult_iter.sv
// Directed and model-checked bench for booth4_mult_iter at WIDTH=8 and WIDTH=64.
module tb_booth4_mult_iter;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   checks = 0;
    int   errors = 0;

    booth4_mult_iter_if #(.WIDTH(8))  if8 ();
    booth4_mult_iter_if #(.WIDTH(64)) if64 ();

    booth4_mult_iter #(.WIDTH(8))  dut8  (.clk(clk), .rst_n(rst_n), .bus(if8));
    booth4_mult_iter #(.WIDTH(64)) dut64 (.clk(clk), .rst_n(rst_n), .bus(if64));

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [127:0] ref_mul64(input logic s, input logic [63:0] a, input logic [63:0] b);
        logic signed [127:0] sa, sb;
        if (s) begin
            sa = $signed(a);
            sb = $signed(b);
            return sa * sb;
        end else begin
            return {64'd0, a} * {64'd0, b};
        end
    endfunction

    // One 8-bit operation; lat = cycles after the start cycle until done (0 if none).
    task automatic op8(input logic s, input logic [7:0] a, input logic [7:0] b,
                       input int inject_at, input int reset_at,
                       output int lat, output logic busy_mid);
        int   cyc;
        logic got;
        @(posedge clk); #1;
        if8.start = 1'b1; if8.is_signed = s; if8.x = a; if8.y = b;
        @(posedge clk); #1;
        if8.start = 1'b0; if8.is_signed = ~s;
        if8.x = 8'($urandom); if8.y = 8'($urandom);
        cyc = 0; got = 1'b0; lat = 0; busy_mid = 1'b0;
        while (cyc < 40 && !got) begin
            cyc++;
            if (cyc == 1) busy_mid = if8.busy;
            if (if8.done) begin
                got = 1'b1;
                lat = cyc;
            end else begin
                if (cyc == inject_at) begin
                    if8.start = 1'b1; if8.x = 8'h11; if8.y = 8'h22; if8.is_signed = 1'b0;
                end else begin
                    if8.start = 1'b0;
                end
                rst_n = (cyc == reset_at) ? 1'b0 : 1'b1;
                @(posedge clk); #1;
            end
        end
        if8.start = 1'b0;
        rst_n = 1'b1;
    endtask

    task automatic op64(input logic s, input logic [63:0] a, input logic [63:0] b, output int lat);
        int cyc;
        @(posedge clk); #1;
        if64.start = 1'b1; if64.is_signed = s; if64.x = a; if64.y = b;
        @(posedge clk); #1;
        if64.start = 1'b0; if64.is_signed = ~s; if64.x = ~a; if64.y = ~b;
        cyc = 0; lat = 0;
        while (cyc < 80 && lat == 0) begin
            cyc++;
            if (if64.done) lat = cyc;
            else begin
                @(posedge clk); #1;
            end
        end
    endtask

    typedef struct {
        logic        s;
        logic [7:0]  a;
        logic [7:0]  b;
        logic [15:0] exp;
    } vec8_t;

    initial begin
        int     lat;
        logic   bm;
        logic   s;
        logic [63:0] a, b;
        vec8_t  vecs[6];

        if8.start = 1'b0; if8.is_signed = 1'b0; if8.x = 8'd0; if8.y = 8'd0;
        if64.start = 1'b0; if64.is_signed = 1'b0; if64.x = 64'd0; if64.y = 64'd0;
        repeat (3) @(posedge clk);
        #1;
        check("reset_busy", {127'd0, if8.busy}, 128'd0);
        check("reset_done", {127'd0, if8.done}, 128'd0);
        check("reset_result", {112'd0, if8.result}, 128'd0);
        check("reset_result64", if64.result, 128'd0);
        rst_n = 1'b1;

        op8(1'b1, 8'hFF, 8'hFF, 0, 0, lat, bm);
        check("s_ff_ff_result", {112'd0, if8.result}, 128'h0001);
        check("s_ff_ff_latency", lat, 128'd6);
        check("busy_in_calc", {127'd0, bm}, 128'd1);

        vecs[0] = '{1'b0, 8'hFF, 8'hFF, 16'hFE01};
        vecs[1] = '{1'b1, 8'h80, 8'h80, 16'h4000};
        vecs[2] = '{1'b1, 8'h7F, 8'h7F, 16'h3F01};
        vecs[3] = '{1'b1, 8'h02, 8'hFD, 16'hFFFA};
        vecs[4] = '{1'b0, 8'h02, 8'hFD, 16'h01FA};
        vecs[5] = '{1'b0, 8'h80, 8'h80, 16'h4000};
        foreach (vecs[i]) begin
            op8(vecs[i].s, vecs[i].a, vecs[i].b, 0, 0, lat, bm);
            check($sformatf("vec%0d_result", i), {112'd0, if8.result}, {112'd0, vecs[i].exp});
            check($sformatf("vec%0d_latency", i), lat, 128'd6);
        end

        op8(1'b1, 8'h80, 8'h7F, 2, 0, lat, bm);
        check("ignored_start_result", {112'd0, if8.result}, 128'hC080);
        check("ignored_start_latency", lat, 128'd6);
        @(posedge clk); #1;
        check("idle_after_done_busy", {127'd0, if8.busy}, 128'd0);

        op8(1'b0, 8'h33, 8'h44, 0, 3, lat, bm);
        check("reset_mid_no_done", lat, 128'd0);
        check("reset_mid_result", {112'd0, if8.result}, 128'd0);
        check("reset_mid_busy", {127'd0, if8.busy}, 128'd0);
        op8(1'b0, 8'h03, 8'h05, 0, 0, lat, bm);
        check("after_reset_3x5", {112'd0, if8.result}, 128'h000F);

        op8(1'b0, 8'h00, 8'h5A, 0, 0, lat, bm);
        check("zero_result", {112'd0, if8.result}, 128'd0);
`ifdef BOOTH4_ZERO_BYPASS_EN
        check("zero_latency", lat, 128'd1);
`else
        check("zero_latency", lat, 128'd6);
`endif

        op64(1'b1, {64{1'b1}}, {64{1'b1}}, lat);
        check("w64_s_ones", if64.result, 128'd1);
        check("w64_s_ones_latency", lat, 128'd34);
        op64(1'b0, {64{1'b1}}, {64{1'b1}}, lat);
        check("w64_u_ones", if64.result, 128'hFFFFFFFFFFFFFFFE_0000000000000001);
        op64(1'b1, 64'h8000000000000000, 64'h8000000000000000, lat);
        check("w64_s_minneg", if64.result, 128'h4000000000000000_0000000000000000);

        for (int i = 0; i < 300; i++) begin
            s = 1'($urandom);
            a = {$urandom, $urandom};
            b = {$urandom, $urandom};
            op64(s, a, b, lat);
            check($sformatf("w64_rand%0d", i), if64.result, ref_mul64(s, a, b));
            check($sformatf("w64_rand%0d_latency", i), lat, 128'd34);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
